// File: rtl/bpred_if.sv
// bpred_if: fetch/execute-facing signals of the branch predictor
//   master (core side): drives pc_f and the upd_* resolution fields, reads the prediction and stats
//   slave  (bpred):     reads pc_f and upd_*, drives pred_taken/pred_target and stat_branches/stat_mispred
interface bpred_if #(
    parameter int DATAW = 32
);
    logic             pc_f_unused_guard;
    logic [DATAW-1:0] pc_f;
    logic             pred_taken;
    logic [DATAW-1:0] pred_target;
    logic             upd_valid;
    logic [DATAW-1:0] upd_pc;
    logic             upd_taken;
    logic [DATAW-1:0] upd_target;
    logic             upd_pred_taken;
    logic [DATAW-1:0] upd_pred_target;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispred;

    modport master (
        output pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, stat_branches, stat_mispred
    );

    modport slave (
        input  pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, stat_branches, stat_mispred
    );
endinterface

// File: rtl/bpred.sv
// bpred: direct-mapped 2-bit saturating-counter branch predictor with tagged targets
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bpred_if.slave -- combinational lookup (pc_f -> pred_taken/pred_target),
//              resolved-branch training (upd_*), and stat_branches/stat_mispred
//   Macro BPRED_STATS_EN builds the branch/mispredict counters; otherwise the stat ports read 0.
module bpred #(
    parameter int DATAW = 32,
    parameter int IDXW  = 6
) (
    input logic   clk,
    input logic   rst,
    bpred_if.slave bus
);
    localparam int DEPTH = 1 << IDXW;
    localparam int TAGW  = DATAW - IDXW - 2;

    logic             valid    [DEPTH];
    logic [TAGW-1:0]  tag_q    [DEPTH];
    logic [DATAW-1:0] target_q [DEPTH];
    logic [1:0]       ctr      [DEPTH];

    logic [IDXW-1:0] f_idx, u_idx;
    logic [TAGW-1:0] f_tag, u_tag;
    logic            f_hit, u_hit;

    assign f_idx = bus.pc_f[IDXW+1:2];
    assign f_tag = bus.pc_f[DATAW-1:IDXW+2];
    assign u_idx = bus.upd_pc[IDXW+1:2];
    assign u_tag = bus.upd_pc[DATAW-1:IDXW+2];
    assign f_hit = valid[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid[u_idx] && (tag_q[u_idx] == u_tag);

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign bus.pred_taken  = f_hit & ctr[f_idx][1];
    assign bus.pred_target = bus.pred_taken ? target_q[f_idx] : bus.pc_f + DATAW'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i]    <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr[i]      <= 2'b01;
            end
        end else if (bus.upd_valid) begin
            if (u_hit) begin
                ctr[u_idx] <= bus.upd_taken ? ((ctr[u_idx] == 2'b11) ? 2'b11 : ctr[u_idx] + 2'd1)
                                            : ((ctr[u_idx] == 2'b00) ? 2'b00 : ctr[u_idx] - 2'd1);
                if (bus.upd_taken) target_q[u_idx] <= bus.upd_target;
            end else if (bus.upd_taken) begin
                // Taken miss replaces whatever aliased entry lives at this index.
                valid[u_idx]    <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= bus.upd_target;
                ctr[u_idx]      <= 2'b10;
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic        mispred;
    logic [31:0] n_branches, n_mispred;
    logic [1:0]  unused_low;

    assign unused_low = bus.pc_f[1:0] ^ bus.upd_pc[1:0];
    assign mispred = (bus.upd_pred_taken != bus.upd_taken) ||
                     (bus.upd_taken && (bus.upd_pred_target != bus.upd_target));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_branches <= '0;
            n_mispred  <= '0;
        end else if (bus.upd_valid) begin
            n_branches <= n_branches + 32'd1;
            if (mispred) n_mispred <= n_mispred + 32'd1;
        end
    end

    assign bus.stat_branches = n_branches;
    assign bus.stat_mispred  = n_mispred;
`else
    logic unused_upd;

    assign unused_upd = ^{bus.upd_pred_taken, bus.upd_pred_target, bus.pc_f[1:0], bus.upd_pc[1:0]};
    assign bus.stat_branches = '0;
    assign bus.stat_mispred  = '0;
`endif
endmodule

// File: doc/bpred.md
# bpred

Branch predictor for the core's fetch stage: a direct-mapped table of 2-bit saturating counters with tagged branch targets. Fetch queries it combinationally with the current PC and receives a next-PC guess. The execute stage writes back each resolved conditional branch, with the `taken` result from the branch comparator, so the table trains on actual outcomes. It is the consumer side of the branch-resolution path and closes the loop between execute and fetch.

## Interface
Parameters:
- `DATAW`, 32, address/data width.
- `IDXW`, 6, index width; table depth is 2^IDXW entries.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_f`  in  DATAW  fetch PC being predicted.
- `pred_taken`  out  1  predicted taken for `pc_f`.
- `pred_target`  out  DATAW  predicted next PC for `pc_f`.
- `upd_valid`  in  1  a conditional branch resolved this cycle.
- `upd_pc`  in  DATAW  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome from the branch comparator.
- `upd_target`  in  DATAW  actual branch target (PC + imm).
- `upd_pred_taken`  in  1  prediction that was made for this branch, carried down the pipe.
- `upd_pred_target`  in  DATAW  predicted target that was made for this branch.
- `stat_branches`  out  32  resolved-branch count; present only with stats (see Configuration).
- `stat_mispred`  out  32  misprediction count; present only with stats.

## Operation
- Address split:
  - index = `pc[IDXW+1:2]`;
  - tag = `pc[DATAW-1:IDXW+2]`;
  - `pc[1:0]` ignored.
- Entry state: `valid` (1 bit), `tag`, `target` (DATAW bits), `ctr` (2 bits).
- Counter encoding:
  - 00 strong not-taken;
  - 01 weak not-taken;
  - 10 weak taken;
  - 11 strong taken.
- Lookup (combinational from `pc_f`):
  - hit = `valid & (tag == pc_f tag)`;
  - `pred_taken = hit & ctr[1]`;
  - `pred_target = pred_taken ? target : pc_f + 4`, with the add truncated to DATAW bits.
- Update, on a clock edge with `upd_valid`=1:
  - Hit at the `upd_pc` index: `ctr` increments (saturating at 11) if `upd_taken`, otherwise decrements (saturating at 00). When `upd_taken`=1, `target` ← `upd_target`.
  - Miss and `upd_taken`=1: allocate, overwriting any existing entry. Set `valid`=1, tag ← `upd_pc` tag, `target` ← `upd_target`, `ctr`=10.
  - Miss and `upd_taken`=0: no change.
- With `upd_valid`=0, the table does not change.
- Misprediction:
  - `upd_pred_taken != upd_taken`, or
  - `upd_taken & (upd_pred_target != upd_target)`.

## Timing
- Prediction latency is 0 cycles; the outputs are purely combinational from `pc_f` and table state.
- An update becomes visible to lookup starting the cycle after the edge that writes it.
- Same-index lookup and update in the same cycle: lookup returns the pre-update entry. There is no bypass.
- Reset, asynchronous and effective immediately, including mid-operation:
  - all `valid`=0, `ctr`=01, `tag`=0, `target`=0;
  - hence `pred_taken`=0 and `pred_target`=`pc_f`+4;
  - stat counters = 0.
- An update asserted in the same cycle `rst` is high is discarded.
- Aliasing: a tag mismatch at an occupied index is a miss. A taken update replaces the entry; a not-taken update leaves it intact.

## Configuration
- Macro `BPRED_STATS_EN`.
- Defined:
  - `stat_branches` increments on every `upd_valid` cycle;
  - `stat_mispred` increments when `upd_valid` and the update is a misprediction;
  - both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined:
  - the ports remain and are tied to 0;
  - no counter logic is built.

## Test plan
- Reset, then sweep `pc_f` over 0x0, 0x100, 0xFFFFFFFC → `pred_taken`=0 and `pred_target`=`pc_f`+4, with 0xFFFFFFFC wrapping to 0x0.
- Update pc 0x80, taken, target 0x40 (allocates with `ctr`=10); next cycle `pc_f`=0x80 → `pred_taken`=1, `pred_target`=0x40. Then one not-taken update → `ctr`=01, `pred_taken`=0. Then 3 not-taken updates → `ctr` holds at 00, and 2 taken updates are needed to predict taken again.
- Alias case with IDXW=6: pc 0x80 allocated, then a taken update at 0x180 (same index, different tag) → 0x80 misses and predicts not-taken, 0x180 predicts taken. A not-taken update at 0x80 leaves the 0x180 entry unchanged.
- Same-cycle lookup and update of the same new taken branch → the prediction that cycle is not-taken; the following cycle predicts taken.
- Assert `rst` asynchronously between edges after training several entries → outputs return to not-taken/`pc_f`+4 before the next edge; an update held during reset is discarded.
- With `BPRED_STATS_EN`: 5 updates, of which 2 have a wrong direction and 1 is correct in direction but has a wrong target → `stat_branches`=5, `stat_mispred`=3. Preload a counter to 0xFFFFFFFF → it wraps to 0. Without the macro, both ports read 0.
